instr_buffer_mw: RTL

- Multi-wide successor of the single-entry fetch/decode instruction FIFO.
- Accepts up to PUSH_W instructions per cycle from fetch as an in-order bundle, and presents up to POP_W oldest entries per cycle to a superscalar decoder.
- Carries branch-predictor metadata per entry.
- Sits between fetch and decode; flushed wholesale on mispredict.

---
 rtl/ibuf_pkg.sv | 22 ++
 rtl/ibuf_checker.sv | 28 ++
 rtl/ibuf_perf.sv | 45 ++++
 rtl/instr_buffer_mw.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ibuf_pkg.sv
// Shared types and default sizing for the multi-wide instruction buffer.
// Optional performance counters are enabled with the IBUF_PERF_EN macro.
package ibuf_pkg;

    localparam int XLEN            = 32;
    localparam int GHR_W           = 8;
    localparam int IBUF_DEPTH_DEF  = 16;
    localparam int IBUF_PUSH_W_DEF = 2;
    localparam int IBUF_POP_W_DEF  = 2;
    localparam int PERF_W          = 32;
    localparam int PERF_FLUSH_W    = 16;

    // One buffered instruction with its branch-predictor context.
    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  inst;
        logic             bp_pred_taken;
        logic [XLEN-1:0]  bp_pred_target;
        logic [GHR_W-1:0] bp_ghr_snapshot;
    } ibuf_entry_t;

endpackage

// File: rtl/ibuf_checker.sv
// Protocol and occupancy checks for instr_buffer_mw; contains no design state.
module ibuf_checker #(
    parameter int DEPTH  = 16,
    parameter int PUSH_W = 2,
    parameter int POP_W  = 2
) (
    input logic                         clock,
    input logic                         reset,
    input logic [$clog2(PUSH_W+1)-1:0]  push_cnt,
    input logic [$clog2(POP_W+1)-1:0]   pop_cnt,
    input logic [$clog2(DEPTH+1)-1:0]   count
);

    // Over-wide bundles and occupancy overflow are errors; a pop beyond occupancy is only flagged.
    always @(posedge clock) begin
        if (reset) begin
            assert (int'(push_cnt) <= PUSH_W)
                else $error("ibuf: push_cnt_i exceeds PUSH_W");
            assert (int'(pop_cnt) <= POP_W)
                else $error("ibuf: pop_cnt_i exceeds POP_W");
            assert (int'(count) <= DEPTH)
                else $error("ibuf: occupancy exceeds DEPTH");
            assert (int'(pop_cnt) <= int'(count))
                else $warning("ibuf: pop request clamped to occupancy");
        end
    end

endmodule

// File: rtl/ibuf_perf.sv
// Saturating occupancy/stall/flush event counters for the instruction buffer.
// Present only when IBUF_PERF_EN is defined; cleared by reset, never by flush.
`ifdef IBUF_PERF_EN
module ibuf_perf
    import ibuf_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    full_stall_ev,
    input  logic                    empty_ev,
    input  logic                    flush_ev,
    output logic [PERF_W-1:0]       perf_full_stall_o,
    output logic [PERF_W-1:0]       perf_empty_cycles_o,
    output logic [PERF_FLUSH_W-1:0] perf_flush_o
);

    logic [PERF_W-1:0]       full_stall_r;
    logic [PERF_W-1:0]       empty_r;
    logic [PERF_FLUSH_W-1:0] flush_r;

    // Each counter sticks at all-ones once reached.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full_stall_r <= {PERF_W{1'b0}};
            empty_r      <= {PERF_W{1'b0}};
            flush_r      <= {PERF_FLUSH_W{1'b0}};
        end else begin
            if (full_stall_ev && (full_stall_r != {PERF_W{1'b1}})) begin
                full_stall_r <= full_stall_r + PERF_W'(1);
            end
            if (empty_ev && (empty_r != {PERF_W{1'b1}})) begin
                empty_r <= empty_r + PERF_W'(1);
            end
            if (flush_ev && (flush_r != {PERF_FLUSH_W{1'b1}})) begin
                flush_r <= flush_r + PERF_FLUSH_W'(1);
            end
        end
    end

    assign perf_full_stall_o   = full_stall_r;
    assign perf_empty_cycles_o = empty_r;
    assign perf_flush_o        = flush_r;

endmodule
`endif

// File: rtl/instr_buffer_mw.sv
// Multi-wide fetch-to-decode instruction buffer with branch-predictor metadata.
// Define IBUF_PERF_EN to add saturating performance counter outputs.
module instr_buffer_mw
    import ibuf_pkg::*;
#(
    parameter int DEPTH  = IBUF_DEPTH_DEF,
    parameter int PUSH_W = IBUF_PUSH_W_DEF,
    parameter int POP_W  = IBUF_POP_W_DEF,
    parameter int GH     = GHR_W
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush_i,
    input  logic [$clog2(PUSH_W+1)-1:0]    push_cnt_i,
    input  logic [PUSH_W-1:0][31:0]        push_pc_i,
    input  logic [PUSH_W-1:0][31:0]        push_inst_i,
    input  logic [PUSH_W-1:0]              push_bp_pred_taken_i,
    input  logic [PUSH_W-1:0][31:0]        push_bp_pred_target_i,
    input  logic [PUSH_W-1:0][GH-1:0]      push_bp_ghr_snapshot_i,
    output logic                           push_ready_o,
    output logic [$clog2(DEPTH+1)-1:0]     free_cnt_o,
    input  logic [$clog2(POP_W+1)-1:0]     pop_cnt_i,
    output logic [POP_W-1:0]               pop_valid_o,
    output logic [POP_W-1:0][31:0]         pop_pc_o,
    output logic [POP_W-1:0][31:0]         pop_inst_o,
    output logic [POP_W-1:0]               pop_bp_pred_taken_o,
    output logic [POP_W-1:0][31:0]         pop_bp_pred_target_o,
    output logic [POP_W-1:0][GH-1:0]       pop_bp_ghr_snapshot_o,
`ifdef IBUF_PERF_EN
    output logic [PERF_W-1:0]              perf_full_stall_o,
    output logic [PERF_W-1:0]              perf_empty_cycles_o,
    output logic [PERF_FLUSH_W-1:0]        perf_flush_o,
`endif
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int PSH_CW = $clog2(PUSH_W+1);

    // GH wider than GHR_W would be truncated in storage; keep GH <= GHR_W.
    ibuf_entry_t      mem_r [DEPTH];
    ibuf_entry_t      push_entry_s [PUSH_W];

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] free_cnt_r;
    logic             push_ready_r;

    logic             do_push_s;
    logic [CNT_W-1:0] push_amt_s;
    logic [CNT_W-1:0] pop_req_s;
    logic [CNT_W-1:0] pop_eff_s;
    logic [CNT_W-1:0] count_next_s;
    logic [CNT_W-1:0] free_next_s;
    logic [PTR_W-1:0] head_next_s;
    logic [PTR_W-1:0] tail_next_s;
    logic             push_ready_next_s;

    // Pack the incoming lanes into storage entries.
    always_comb begin
        for (int j = 0; j < PUSH_W; j++) begin
            push_entry_s[j].pc              = push_pc_i[j];
            push_entry_s[j].inst            = push_inst_i[j];
            push_entry_s[j].bp_pred_taken   = push_bp_pred_taken_i[j];
            push_entry_s[j].bp_pred_target  = push_bp_pred_target_i[j];
            push_entry_s[j].bp_ghr_snapshot = GHR_W'(push_bp_ghr_snapshot_i[j]);
        end
    end

    // Next-state pointer and occupancy math; readiness comes from the pre-edge count only.
    always_comb begin
        do_push_s = push_ready_r && (push_cnt_i != PSH_CW'(0));

        if (do_push_s) begin
            push_amt_s = CNT_W'(push_cnt_i);
        end else begin
            push_amt_s = CNT_W'(0);
        end

        pop_req_s = CNT_W'(pop_cnt_i);
        if (pop_req_s > count_r) begin
            pop_eff_s = count_r;
        end else begin
            pop_eff_s = pop_req_s;
        end

        if (flush_i) begin
            count_next_s = CNT_W'(0);
            head_next_s  = PTR_W'(0);
            tail_next_s  = PTR_W'(0);
        end else begin
            count_next_s = count_r + push_amt_s - pop_eff_s;
            head_next_s  = head_r + pop_eff_s[PTR_W-1:0];
            tail_next_s  = tail_r + push_amt_s[PTR_W-1:0];
        end

        free_next_s       = CNT_W'(DEPTH) - count_next_s;
        push_ready_next_s = (free_next_s >= CNT_W'(PUSH_W));
    end

    // Control state; status outputs are registered alongside the count they derive from.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_r       <= PTR_W'(0);
            tail_r       <= PTR_W'(0);
            count_r      <= CNT_W'(0);
            free_cnt_r   <= CNT_W'(DEPTH);
            push_ready_r <= 1'b1;
        end else begin
            head_r       <= head_next_s;
            tail_r       <= tail_next_s;
            count_r      <= count_next_s;
            free_cnt_r   <= free_next_s;
            push_ready_r <= push_ready_next_s;
        end
    end

    // Storage array is deliberately unreset; lanes land at consecutive slots from tail.
    always_ff @(posedge clock) begin
        for (int j = 0; j < PUSH_W; j++) begin
            if (do_push_s && !flush_i && (PSH_CW'(j) < push_cnt_i)) begin
                mem_r[tail_r + PTR_W'(j)] <= push_entry_s[j];
            end
        end
    end

    for (genvar i = 0; i < POP_W; i++) begin : g_pop
        logic [PTR_W-1:0] rd_idx_s;
        assign rd_idx_s                 = head_r + PTR_W'(i);
        assign pop_valid_o[i]           = (count_r > CNT_W'(i));
        assign pop_pc_o[i]              = mem_r[rd_idx_s].pc;
        assign pop_inst_o[i]            = mem_r[rd_idx_s].inst;
        assign pop_bp_pred_taken_o[i]   = mem_r[rd_idx_s].bp_pred_taken;
        assign pop_bp_pred_target_o[i]  = mem_r[rd_idx_s].bp_pred_target;
        assign pop_bp_ghr_snapshot_o[i] = GH'(mem_r[rd_idx_s].bp_ghr_snapshot);
    end

    assign count_o      = count_r;
    assign free_cnt_o   = free_cnt_r;
    assign push_ready_o = push_ready_r;

`ifdef IBUF_PERF_EN
    ibuf_perf u_perf (
        .clock               (clock),
        .reset               (reset),
        .full_stall_ev       ((push_cnt_i != PSH_CW'(0)) && !push_ready_r),
        .empty_ev            ((count_r == CNT_W'(0)) && !flush_i),
        .flush_ev            (flush_i),
        .perf_full_stall_o   (perf_full_stall_o),
        .perf_empty_cycles_o (perf_empty_cycles_o),
        .perf_flush_o        (perf_flush_o)
    );
`endif

    ibuf_checker #(
        .DEPTH  (DEPTH),
        .PUSH_W (PUSH_W),
        .POP_W  (POP_W)
    ) u_checker (
        .clock    (clock),
        .reset    (reset),
        .push_cnt (push_cnt_i),
        .pop_cnt  (pop_cnt_i),
        .count    (count_r)
    );

endmodule
